pwm_breathe_array: RTL and testbench

Multi-channel LED brightness engine for the TinyFPGA board designs. It drives `CHANNELS` LED outputs from one shared PWM/step counter. Each channel runs independently in one of four modes: off, solid, breathe (triangle ramp) or blink (square wave). The block sits between top-level mode/brightness control and the LED pins, and is the generalised successor to the single-LED heartbeat.

---
 rtl/pwm_breathe_array.sv | 127 ++++++++++++
 tb/tb_pwm_breathe_array.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_breathe_array.sv
// pwm_breathe_array
//   Multi-channel LED brightness engine. One shared free-running counter
//   supplies both the PWM frame position (low PWM_W bits) and the ramp step
//   tick (counter all ones). Each channel is independently off, solid,
//   breathe (triangle ramp 0..peak..0) or blink (square wave at peak).
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   mode        per-channel mode, bits [2i+1:2i] for channel i
//               (00 off, 01 solid, 10 breathe, 11 blink)
//   peak        shared ramp top / solid and blink level
//   sync        single-cycle pulse: restart every ramp in phase
//   led         registered PWM outputs, one per channel
//   cycle_done  one-cycle pulse when channel 0 finishes a ramp period
module pwm_breathe_array #(
  parameter int CHANNELS   = 4,
  parameter int PWM_W      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [PWM_W-1:0]      peak,
  input  logic                  sync,
  output logic [CHANNELS-1:0]   led,
  output logic                  cycle_done
);

  localparam int CNT_W = PWM_W + PRESCALE_W;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_SOLID   = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_BLINK   = 2'b11;

  localparam logic [PWM_W-1:0] LVL_ZERO = '0;
  localparam logic [PWM_W-1:0] LVL_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]    cnt;
  logic [PWM_W-1:0]    frame;
  logic                tick;

  logic [PWM_W-1:0]    level     [CHANNELS];
  logic [PWM_W-1:0]    level_nxt [CHANNELS];
  logic [PWM_W-1:0]    eff       [CHANNELS];
  logic [CHANNELS-1:0] dir;
  logic [CHANNELS-1:0] dir_nxt;
  logic [CHANNELS-1:0] led_nxt;
  logic                cycle_done_nxt;

  assign frame = cnt[PWM_W-1:0];
  // sync owns this cycle: it restarts the counter, so no step happens.
  assign tick  = (&cnt) & ~sync;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      level_nxt[i] = level[i];
      dir_nxt[i]   = dir[i];
      eff[i]       = LVL_ZERO;

      case (mode[2*i +: 2])
        MODE_OFF: begin
          level_nxt[i] = LVL_ZERO;
          dir_nxt[i]   = 1'b1;
        end
        MODE_SOLID: begin
          level_nxt[i] = peak;
          dir_nxt[i]   = 1'b0;
          eff[i]       = level[i];
        end
        default: begin
          eff[i] = (mode[2*i +: 2] == MODE_BLINK) ? (dir[i] ? peak : LVL_ZERO)
                                                   : level[i];
          if (sync) begin
            level_nxt[i] = LVL_ZERO;
            dir_nxt[i]   = 1'b1;
          end else if (tick) begin
            if (dir[i]) begin
              // >= also catches a peak lowered below the current level.
              if (level[i] >= peak) begin
                if (peak == LVL_ZERO) begin
                  level_nxt[i] = LVL_ZERO;
                  dir_nxt[i]   = 1'b1;
                end else begin
                  level_nxt[i] = peak - LVL_ONE;
                  dir_nxt[i]   = 1'b0;
                end
              end else begin
                level_nxt[i] = level[i] + LVL_ONE;
              end
            end else begin
              if (level[i] == LVL_ZERO) begin
                level_nxt[i] = (peak == LVL_ZERO) ? LVL_ZERO : LVL_ONE;
                dir_nxt[i]   = 1'b1;
              end else begin
                level_nxt[i] = level[i] - LVL_ONE;
              end
            end
          end
        end
      endcase

      led_nxt[i] = eff[i] > frame;
    end

    // Bottom of the down ramp on channel 0 marks the end of one period.
    cycle_done_nxt = tick && mode[1] && !dir[0] && (level[0] == LVL_ZERO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      led        <= '0;
      cycle_done <= 1'b0;
      dir        <= '1;
      for (int i = 0; i < CHANNELS; i++) level[i] <= LVL_ZERO;
    end else begin
      cnt        <= sync ? '0 : cnt + 1'b1;
      led        <= led_nxt;
      cycle_done <= cycle_done_nxt;
      dir        <= dir_nxt;
      for (int i = 0; i < CHANNELS; i++) level[i] <= level_nxt[i];
    end
  end

endmodule

// File: tb/tb_pwm_breathe_array.sv
module tb_pwm_breathe_array;

  localparam int CH     = 2;
  localparam int PW     = 4;
  localparam int PS     = 2;
  localparam int FRAME  = 16;
  localparam int PERIOD = 64;

  logic          clk = 0;
  logic          rst;
  logic [2*CH-1:0] mode;
  logic [PW-1:0] peak;
  logic          sync;
  logic [CH-1:0] led;
  logic          cycle_done;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model state (plain integers)
  int   m_cnt;
  int   m_level [CH];
  int   m_dir   [CH];
  logic [CH-1:0] m_led;
  logic m_cd;

  typedef struct {
    logic [2*CH-1:0] mode;
    int pk;
    int exp_hi0;
    int exp_hi1;
  } vec_t;

  vec_t vecs [6];

  pwm_breathe_array #(.CHANNELS(CH), .PWM_W(PW), .PRESCALE_W(PS)) dut (
    .clk(clk), .rst(rst), .mode(mode), .peak(peak), .sync(sync),
    .led(led), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference behaviour for one clock edge, from the inputs present at it.
  task automatic model_edge();
    int md, pk, eff, frm;
    bit tk;
    logic [CH-1:0] nl;
    if (rst) begin
      m_cnt = 0; m_led = '0; m_cd = 0;
      for (int c = 0; c < CH; c++) begin m_level[c] = 0; m_dir[c] = 1; end
      return;
    end
    pk  = int'(peak);
    frm = m_cnt % FRAME;
    tk  = !sync && (m_cnt == PERIOD - 1);
    for (int c = 0; c < CH; c++) begin
      md = int'(mode) >> (2*c) & 3;
      if (md == 0)      eff = 0;
      else if (md == 3) eff = m_dir[c] ? pk : 0;
      else              eff = m_level[c];
      nl[c] = eff > frm;
    end
    m_cd = tk && ((int'(mode) & 3) >= 2) && m_dir[0] == 0 && m_level[0] == 0;
    for (int c = 0; c < CH; c++) begin
      md = int'(mode) >> (2*c) & 3;
      if (md == 0) begin m_level[c] = 0; m_dir[c] = 1; end
      else if (md == 1) begin m_level[c] = pk; m_dir[c] = 0; end
      else if (sync) begin m_level[c] = 0; m_dir[c] = 1; end
      else if (tk) begin
        if (m_dir[c] == 1) begin
          if (m_level[c] < pk) m_level[c]++;
          else if (pk == 0) m_level[c] = 0;
          else begin m_level[c] = pk - 1; m_dir[c] = 0; end
        end else begin
          if (m_level[c] > 0) m_level[c]--;
          else begin m_level[c] = (pk == 0) ? 0 : 1; m_dir[c] = 1; end
        end
      end
    end
    m_led = nl;
    m_cnt = sync ? 0 : (m_cnt + 1) % PERIOD;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("led", 32'(led), 32'(m_led));
    chk("cycle_done", 32'(cycle_done), 32'(m_cd));
  endtask

  task automatic do_reset(input logic [2*CH-1:0] md, input int pk);
    rst = 1; mode = md; peak = PW'(pk); sync = 0;
    repeat (3) step();
    rst = 0;
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    while (m_cnt != v && n < 200) begin step(); n++; end
    if (m_cnt != v) begin
      n_vec++; n_miss++;
      $display("FAIL wait_cnt timeout: cnt %0d required %0d", m_cnt, v);
    end
  endtask

  task automatic count_hi(input int n, output int h0, output int h1, output int hc);
    h0 = 0; h1 = 0; hc = 0;
    for (int k = 0; k < n; k++) begin
      step();
      h0 += int'(led[0]); h1 += int'(led[1]); hc += int'(cycle_done);
    end
  endtask

  // Steps until led[0] rises; returns the number of steps taken (0 on timeout).
  task automatic steps_to_led0(output int n);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (led[0] === 1'b1) begin n = k; break; end
    end
  endtask

  initial begin
    int h0, h1, hc, n;
    vecs[0] = '{4'b0001, 4,  4, 0};
    vecs[1] = '{4'b0001, 0,  0, 0};
    vecs[2] = '{4'b0101, 15, 15, 15};
    vecs[3] = '{4'b0100, 9,  0, 9};
    vecs[4] = '{4'b0001, 1,  1, 0};
    vecs[5] = '{4'b0000, 12, 0, 0};
    m_cnt = 0; m_led = '0; m_cd = 0;
    for (int c = 0; c < CH; c++) begin m_level[c] = 0; m_dir[c] = 1; end

    // reset, release, first tick after 64 cycles (led rises one cycle later)
    do_reset(4'b1010, 15);
    chk("led_in_reset", 32'(led), 0);
    steps_to_led0(n);
    chk("first_tick_latency", n, 65);

    // solid / off duty table
    for (int v = 0; v < 6; v++) begin
      mode = vecs[v].mode; peak = PW'(vecs[v].pk);
      step(); step();
      wait_cnt(8);
      count_hi(FRAME, h0, h1, hc);
      chk("duty_ch0", h0, vecs[v].exp_hi0);
      chk("duty_ch1", h1, vecs[v].exp_hi1);
    end

    // breathe peak 3: cycle_done period 384
    do_reset(4'b0010, 3);
    n = 0;
    while (cycle_done !== 1'b1 && n < 1000) begin step(); n++; end
    n = 0;
    do begin step(); n++; end while (cycle_done !== 1'b1 && n < 1000);
    chk("cycle_done_period", n, 384);

    // blink ch1 with ch0 off
    do_reset(4'b1100, 3);
    repeat (400) step();
    count_hi(384, h0, h1, hc);
    chk("blink_ch1_highs", h1, 36);
    chk("blink_ch0_off", h0, 0);

    // lowering peak while ramping up at level 10
    do_reset(4'b0010, 15);
    repeat (640) step();
    peak = 5;
    repeat (64) step();
    wait_cnt(8);
    count_hi(FRAME, h0, h1, hc);
    chk("peak_clamp_level", h0, 4);
    peak = 0;
    repeat (384) step();
    count_hi(384, h0, h1, hc);
    chk("peak0_dark", h0, 0);
    chk("peak0_no_done", hc, 0);

    // sync coincident with a tick, channels at different levels
    do_reset(4'b0010, 15);
    repeat (192) step();
    mode = 4'b1010;
    repeat (128) step();
    wait_cnt(63);
    sync = 1;
    step();
    sync = 0;
    chk("sync_cnt_restart", m_cnt, 0);
    count_hi(63, h0, h1, hc);
    chk("sync_dark_ch0", h0, 0);
    chk("sync_dark_ch1", h1, 0);
    chk("sync_no_done", hc, 0);
    steps_to_led0(n);
    chk("sync_next_tick", n, 2);

    // reset mid-ramp
    repeat (300) step();
    rst = 1; step(); rst = 0;
    chk("midramp_reset_led", 32'(led), 0);
    repeat (70) step();

    // randomized traffic against the model
    mode = 4'($urandom); peak = 4'($urandom);
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 63) == 0) mode = 4'($urandom);
      if ($urandom_range(0, 63) == 0) peak = 4'($urandom);
      sync = ($urandom_range(0, 299) == 0);
      rst  = ($urandom_range(0, 1999) == 0);
      step();
    end
    sync = 0; rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
